// File: rtl/barrel_shifter_pipe_if.sv
// Valid/ready stream interface for barrel_shifter_pipe (operand side and result side).
// out_carry exists only when BSHIFT_CARRY_EN is defined.
interface barrel_shifter_pipe_if #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic               in_dir;
   logic [1:0]         in_mode;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
`ifdef BSHIFT_CARRY_EN
   logic               out_carry;
`endif

   // Producer/consumer side
   modport master (
      output in_valid, in_data, in_shamt, in_dir, in_mode, out_ready,
      input  in_ready, out_valid, out_data
`ifdef BSHIFT_CARRY_EN
      , input out_carry
`endif
   );

   // Shifter side
   modport slave (
      input  in_valid, in_data, in_shamt, in_dir, in_mode, out_ready,
      output in_ready, out_valid, out_data
`ifdef BSHIFT_CARRY_EN
      , output out_carry
`endif
   );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined power-of-two barrel shifter: capture rank plus one register rank per log2 mux layer.
// Define BSHIFT_CARRY_EN to add out_carry (last bit shifted out), pipelined alongside the data.
module barrel_shifter_pipe #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   barrel_shifter_pipe_if.slave bus
);
   localparam int unsigned NRANK       = SHAMT_W + 1;
   localparam logic [1:0]  MODE_LOGIC  = 2'b00;
   localparam logic [1:0]  MODE_ROTATE = 2'b01;
   localparam logic [1:0]  MODE_ARITH  = 2'b10;
   localparam logic [1:0]  MODE_RSVD   = 2'b11;

   if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0 || SHAMT_W != $clog2(WIDTH)) begin : g_bad_param
      $error("barrel_shifter_pipe: WIDTH must be a power of two in 4..64 and SHAMT_W left at default");
   end

   // Rank 0 holds the captured operand; rank k+1 holds the result of mux layer k.
   logic [WIDTH-1:0]   data_q  [NRANK];
   logic [SHAMT_W-1:0] shamt_q [NRANK];
   logic [1:0]         mode_q  [NRANK];
   logic               dir_q   [NRANK];
   logic               valid_q [NRANK];
   logic [WIDTH-1:0]   res_c   [SHAMT_W];
   logic               adv_c;

   function automatic logic [WIDTH-1:0] shift_pow2(input logic [WIDTH-1:0] d, input int k,
                                                   input logic dir, input logic [1:0] mode);
      int               s;
      logic [WIDTH-1:0] r;
      s = 1 << k;
      if (!dir) begin
         r = (mode == MODE_ROTATE) ? ((d << s) | (d >> (WIDTH - s))) : (d << s);
      end else begin
         case (mode)
            MODE_ROTATE: r = (d >> s) | (d << (WIDTH - s));
            MODE_ARITH:  r = WIDTH'($signed(d) >>> s);
            default:     r = d >> s;
         endcase
      end
      return r;
   endfunction

   // Whole pipe moves together; bubbles are not squeezed out.
   assign adv_c         = !valid_q[SHAMT_W] || bus.out_ready;
   assign bus.in_ready  = adv_c;
   assign bus.out_valid = valid_q[SHAMT_W];
   assign bus.out_data  = data_q[SHAMT_W];

   // Each layer consumes the low bit of its (already right-aligned) shift amount.
   always_comb begin
      for (int k = 0; k < SHAMT_W; k++) begin
         res_c[k] = data_q[k];
         if (shamt_q[k][0] && mode_q[k] != MODE_RSVD && mode_q[k] != MODE_LOGIC + MODE_RSVD) begin
            res_c[k] = shift_pow2(data_q[k], k, dir_q[k], mode_q[k]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NRANK; k++) begin
            data_q[k]  <= '0;
            shamt_q[k] <= '0;
            mode_q[k]  <= '0;
            dir_q[k]   <= 1'b0;
            valid_q[k] <= 1'b0;
         end
      end else if (adv_c) begin
         valid_q[0] <= bus.in_valid;
         if (bus.in_valid) begin
            data_q[0]  <= bus.in_data;
            shamt_q[0] <= bus.in_shamt;
            mode_q[0]  <= bus.in_mode;
            dir_q[0]   <= bus.in_dir;
         end
         for (int k = 0; k < SHAMT_W; k++) begin
            valid_q[k+1] <= valid_q[k];
            if (valid_q[k]) begin
               data_q[k+1]  <= res_c[k];
               shamt_q[k+1] <= shamt_q[k] >> 1;
               mode_q[k+1]  <= mode_q[k];
               dir_q[k+1]   <= dir_q[k];
            end
         end
      end
   end

`ifdef BSHIFT_CARRY_EN
   logic               carry_q [NRANK];
   logic               carry_in_c;
   logic [SHAMT_W-1:0] left_idx_c;
   logic [SHAMT_W-1:0] right_idx_c;

   // Carry is resolved at capture: bit WIDTH-n for left, bit n-1 for right.
   always_comb begin
      left_idx_c  = '0 - bus.in_shamt;
      right_idx_c = bus.in_shamt - SHAMT_W'(1);
      carry_in_c  = 1'b0;
      if (bus.in_shamt != '0 && bus.in_mode != MODE_RSVD) begin
         carry_in_c = bus.in_dir ? bus.in_data[right_idx_c] : bus.in_data[left_idx_c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NRANK; k++) begin
            carry_q[k] <= 1'b0;
         end
      end else if (adv_c) begin
         if (bus.in_valid) begin
            carry_q[0] <= carry_in_c;
         end
         for (int k = 0; k < SHAMT_W; k++) begin
            if (valid_q[k]) begin
               carry_q[k+1] <= carry_q[k];
            end
         end
      end
   end

   assign bus.out_carry = carry_q[SHAMT_W];
`endif
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (WIDTH=8): directed spec cases, backpressure,
// mid-flight reset and randomized streaming against a bit-level reference model.
module tb_barrel_shifter_pipe;
   localparam int unsigned W   = 8;
   localparam int unsigned LAT = 3;

   logic clk = 1'b0;
   logic rst_n;

   barrel_shifter_pipe_if #(.WIDTH(W)) bus ();

   barrel_shifter_pipe #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef BSHIFT_CARRY_EN
   localparam logic [8:0] RES_MASK = 9'h1FF;
   logic obs_carry;
   assign obs_carry = bus.out_carry;
`else
   localparam logic [8:0] RES_MASK = 9'h0FF;
   logic obs_carry;
   assign obs_carry = 1'b0;
`endif

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [8:0] sb_q [$];
   logic [7:0] got_q [$];
   logic       last_acc;
   logic       stall_q  = 1'b0;
   logic [7:0] hold_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: each result bit picks its source bit; out-of-range sources get the fill rule.
   function automatic logic [8:0] model(input logic [7:0] d, input int n, input logic dir,
                                        input logic [1:0] mode);
      logic [7:0] r;
      logic       c;
      int         src;
      r = d;
      c = 1'b0;
      if (mode != 2'b11 && n != 0) begin
         for (int i = 0; i < 8; i++) begin
            src = dir ? i + n : i - n;
            if (src >= 0 && src < 8)       r[i] = d[3'(src)];
            else if (mode == 2'b01)        r[i] = d[3'(src + 8)];
            else if (dir && mode == 2'b10) r[i] = d[7];
            else                           r[i] = 1'b0;
         end
         c = dir ? d[3'(n - 1)] : d[3'(8 - n)];
      end
      return {c, r};
   endfunction

   // One clock: sample handshakes, score transfers, log accepts, then step past the edge.
   task automatic cycle();
      logic [8:0] e;
      #1;
      if (stall_q) begin
         check("hold_valid", 64'(bus.out_valid), 64'(1));
         check("hold_data", 64'(bus.out_data), 64'(hold_data));
      end
      stall_q   = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      last_acc  = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
         check("sb_avail", 64'(sb_q.size() > 0), 64'(1));
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_result", 64'({obs_carry, bus.out_data}), 64'(e & RES_MASK));
         end
         got_q.push_back(bus.out_data);
      end
      if (last_acc) sb_q.push_back(model(bus.in_data, int'(bus.in_shamt), bus.in_dir, bus.in_mode));
      @(posedge clk);
      #1;
   endtask

   // Single operand on an empty pipe: checks acceptance, latency and the spec's expected result.
   task automatic run_one(input string tag, input logic [7:0] d, input logic [2:0] n, input logic dir,
                          input logic [1:0] mode, input logic [8:0] exp);
      int lat;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_shamt  = n;
      bus.in_dir    = dir;
      bus.in_mode   = mode;
      cycle();
      check({tag, "_accept"}, 64'(last_acc), 64'(1));
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 10) begin
         cycle();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(LAT));
      check({tag, "_result"}, 64'({obs_carry, bus.out_data}), 64'(exp & RES_MASK));
      cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exp_seq [5];
      int         idx;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_shamt  = '0;
      bus.in_dir    = 1'b0;
      bus.in_mode   = '0;
      bus.out_ready = 1'b1;
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));
      check("rst_out_data", 64'({obs_carry, bus.out_data}), 64'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      run_one("lsl3",    8'b1011_0110, 3'd3, 1'b0, 2'b00, {1'b1, 8'b1011_0000});
      run_one("asr2",    8'b1000_0001, 3'd2, 1'b1, 2'b10, {1'b0, 8'b1110_0000});
      run_one("lsr2",    8'b1000_0001, 3'd2, 1'b1, 2'b00, {1'b0, 8'b0010_0000});
      run_one("ror1",    8'b1000_0001, 3'd1, 1'b1, 2'b01, {1'b1, 8'b1100_0000});
      run_one("rol7",    8'b1000_0001, 3'd7, 1'b0, 2'b01, {1'b0, 8'b1100_0000});
      run_one("rot0",    8'hA5,        3'd0, 1'b0, 2'b01, {1'b0, 8'hA5});
      run_one("mode3",   8'hA5,        3'd5, 1'b1, 2'b11, {1'b0, 8'hA5});
      run_one("asl7",    8'b0100_0011, 3'd7, 1'b0, 2'b10, {1'b1, 8'b1000_0000});

      // Backpressure: five LSL-by-1 operands against a stalled consumer.
      got_q.delete();
      bus.out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 40 && got_q.size() < 5; c++) begin
         bus.in_valid = (idx < 5);
         bus.in_data  = 8'(idx + 1);
         bus.in_shamt = 3'd1;
         bus.in_dir   = 1'b0;
         bus.in_mode  = 2'b00;
         if (c == 8) bus.out_ready = 1'b1;
         cycle();
         if (last_acc) idx++;
         if (c == 2) begin
            check("bp_pre_valid", 64'(bus.out_valid), 64'(0));
            check("bp_pre_ready", 64'(bus.in_ready), 64'(1));
         end
         if (c >= 3 && c <= 7) begin
            check("bp_stall_valid", 64'(bus.out_valid), 64'(1));
            check("bp_stall_ready", 64'(bus.in_ready), 64'(0));
            check("bp_stall_data", 64'(bus.out_data), 64'(8'h02));
         end
      end
      bus.in_valid = 1'b0;
      exp_seq = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A};
      check("bp_count", 64'(got_q.size()), 64'(5));
      for (int i = 0; i < 5 && i < got_q.size(); i++) check("bp_order", 64'(got_q[i]), 64'(exp_seq[i]));

      // Reset with three operands in flight.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'h11 * (i + 1));
         bus.in_shamt = 3'd1;
         bus.in_dir   = 1'b0;
         bus.in_mode  = 2'b00;
         cycle();
      end
      bus.in_valid = 1'b0;
      cycle();
      check("rstf_pre_valid", 64'(bus.out_valid), 64'(1));
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstf_out_valid", 64'(bus.out_valid), 64'(0));
      check("rstf_in_ready", 64'(bus.in_ready), 64'(1));
      sb_q.delete();
      stall_q = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("rstf_no_stale", 64'(bus.out_valid), 64'(0));
      end
      run_one("post_rst", 8'h3C, 3'd2, 1'b1, 2'b01, {1'b0, 8'h0F});

      // Randomized streaming with random backpressure.
      for (int c = 0; c < 600; c++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = 8'($urandom);
         bus.in_shamt  = 3'($urandom);
         bus.in_dir    = 1'($urandom);
         bus.in_mode   = 2'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20 && sb_q.size() > 0; c++) cycle();
      check("drain_empty", 64'(sb_q.size()), 64'(0));
      check("drain_idle", 64'(bus.out_valid), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined successor to the team's 4-bit combinational barrel shifter. It supports any power-of-two width and keeps the same mode and direction encoding. It uses one register stage per log2 mux layer, with a valid/ready handshake on both sides. It sits between operand staging and the ALU result mux in the datapath.

Parameters:
- WIDTH, 8, data width in bits. Power of two, 4 to 64. Other values are an elaboration error.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  operand present
- in_ready  output  1  block accepts operand this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount, 0 to WIDTH-1
- in_dir  input  1  0 = left, 1 = right
- in_mode  input  2  00 logical, 01 rotate, 10 arithmetic, 11 reserved
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- out_carry  output  1  last bit shifted out; present only with BSHIFT_CARRY_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all stage valids 0, all stage data 0, out_valid=0, out_data=0, out_carry=0. in_ready=1 after reset, since the pipe is empty.
- Pipeline: SHAMT_W stages. Stage k (k=0..SHAMT_W-1) applies a shift of 2^k when the registered shamt bit k is 1; otherwise it passes the data through. Each stage registers data, shamt, dir, mode, valid and carry.
- Latency: exactly SHAMT_W cycles from the accept edge to out_valid, i.e. 3 cycles for WIDTH=8.
- Throughput: 1 operand per cycle when out_ready=1.
- Handshake: adv = !out_valid | out_ready, and in_ready = adv.
  - Accept on in_valid & in_ready. Output transfer on out_valid & out_ready.
  - When adv=0 the whole pipe stalls, bubbles included (no bubble compression).
  - While stalled, out_data and out_valid hold stable.
  - in_ready is combinational from out_valid and out_ready only. It never depends on in_valid.
- Mode semantics:
  - Logical: zero fill.
  - Rotate: modulo WIDTH.
  - Arithmetic right: MSB fill.
  - Arithmetic left: identical to logical left.
  - Mode 11: result = in_data unchanged, carry 0.
- Boundaries:
  - shamt=0: data unchanged in every mode, carry 0.
  - shamt=WIDTH-1 is legal. ROL by n equals ROR by WIDTH-n.
  - Simultaneous output transfer and input accept in the same cycle is normal streaming. No item is lost or duplicated.
- Reset mid-operation: all in-flight items are discarded. out_valid falls asynchronously. No output appears after reset release until new items are accepted.
- Ordering: results leave strictly in accept order.

Optional Feature:
- Macro: BSHIFT_CARRY_EN.
- Defined:
  - out_carry port exists. Its value is computed at input capture and pipelined with the data.
  - Left shift/rotate, n>0: carry = in_data[WIDTH-n].
  - Right shift/rotate/arith, n>0: carry = in_data[n-1].
  - n=0 or mode 11: carry = 0.
- Undefined: the out_carry port and all carry registers are absent. All other behaviour is identical.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- LSL: in_data 8'b1011_0110, shamt 3, dir 0, mode 00 -> out_data 8'b1011_0000, carry 1, 3 cycles after accept.
- ASR: 8'b1000_0001, shamt 2, dir 1, mode 10 -> 8'b1110_0000, carry 0. Then LSR of the same operand -> 8'b0010_0000.
- Rotate equivalence: ROR of 8'b1000_0001 by 1 and ROL of the same operand by 7 -> both 8'b1100_0000. ROR carry 1; ROL carry 0.
- Pass-through cases: shamt 0 in mode 01, and mode 11 with shamt 5, on 8'hA5 -> 8'hA5, carry 0.
- Backpressure: hold out_ready=0 and stream 8'h01..8'h05 as LSL by 1.
  - in_ready falls the cycle out_valid rises.
  - out_data holds 8'h02 stable for 5 cycles.
  - After releasing out_ready: results 02, 04, 06 arrive in order; items 4 and 5 follow with none lost or duplicated.
- Reset mid-flight: pulse rst_n low with 3 items in the pipe -> out_valid=0 immediately. No stale output after release. The next accepted item emerges with latency 3.
